// File: rtl/bitstream_loader_pkg.sv
// Shared state encoding and default timing/size constants for the bitstream loader.
package bitstream_loader_pkg;

   localparam int unsigned DefSetupCycles = 2;
   localparam int unsigned DefHoldCycles  = 2;
   localparam int unsigned DefMaxWords    = 4096;
   localparam int unsigned WordCountW     = 13;

   typedef enum logic [2:0] {
      StCollect,
      StSetup,
      StStrobe,
      StHold,
      StDone
   } packer_state_e;

endpackage

// File: rtl/bitstream_byte_assembler.sv
// Collects bitstream bytes big-endian; flags the transfer that completes a 32-bit word.
module bitstream_byte_assembler (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clear_i,
   input  logic        accept_i,
   input  logic [7:0]  data_i,
   output logic [1:0]  idx_o,
   output logic        word_done_o,
   output logic [31:0] word_o
);

   logic [23:0] shift_q, shift_d;
   logic [1:0]  idx_q, idx_d;

   always_comb begin
      shift_d = shift_q;
      idx_d   = idx_q;
      if (clear_i) begin
         shift_d = '0;
         idx_d   = '0;
      end else if (accept_i) begin
         shift_d = {shift_q[15:0], data_i};
         idx_d   = idx_q + 2'd1;  // wraps to 0 on the fourth byte
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shift_q <= '0;
         idx_q   <= '0;
      end else begin
         shift_q <= shift_d;
         idx_q   <= idx_d;
      end
   end

   assign idx_o       = idx_q;
   assign word_done_o = accept_i & ~clear_i & (idx_q == 2'd3);
   assign word_o      = {shift_q, data_i};

endmodule

// File: rtl/bitstream_word_packer.sv
// Packs bytes into 32-bit words and writes them with setup/strobe/hold timing.
// Define BITSTREAM_PACKER_CHECKSUM_EN to add an XOR checksum of all strobed words.
module bitstream_word_packer
   import bitstream_loader_pkg::*;
#(
   parameter int unsigned SETUP_CYCLES = DefSetupCycles,
   parameter int unsigned HOLD_CYCLES  = DefHoldCycles,
   parameter int unsigned MAX_WORDS    = DefMaxWords
) (
   input  logic                  CLK,
   input  logic                  resetn,
   input  logic                  clear,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [31:0]           SelfWriteData,
   output logic                  SelfWriteStrobe,
   output logic                  ComActive,
   output logic                  done,
   output logic [WordCountW-1:0] word_count
`ifdef BITSTREAM_PACKER_CHECKSUM_EN
   ,
   output logic [31:0]           checksum
`endif
);

   packer_state_e         state_q, state_d;
   logic [15:0]           cnt_q, cnt_d;
   logic [31:0]           data_q, data_d;
   logic [WordCountW-1:0] wc_q, wc_d;
   logic                  strobe_q, strobe_d;
   logic                  done_q, done_d;
   logic                  hold_exit;
   logic                  accept;
   logic                  word_done;
   logic [1:0]            byte_idx;
   logic [31:0]           asm_word;
`ifdef BITSTREAM_PACKER_CHECKSUM_EN
   logic [31:0]           cs_q, cs_d;
`endif

   // clear wins over a byte transfer in the same cycle
   assign accept = in_valid & (state_q == StCollect) & ~clear;

   bitstream_byte_assembler u_assembler (
      .clk_i       (CLK),
      .rst_ni      (resetn),
      .clear_i     (clear),
      .accept_i    (accept),
      .data_i      (in_data),
      .idx_o       (byte_idx),
      .word_done_o (word_done),
      .word_o      (asm_word)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      wc_d      = wc_q;
      done_d    = done_q;
      hold_exit = 1'b0;
`ifdef BITSTREAM_PACKER_CHECKSUM_EN
      cs_d      = cs_q;
`endif
      unique case (state_q)
         StCollect: begin
            if (word_done) begin
               data_d  = asm_word;
               cnt_d   = '0;
               state_d = (SETUP_CYCLES == 0) ? StStrobe : StSetup;
            end
         end
         StSetup: begin
            if (cnt_q == 16'(SETUP_CYCLES - 1)) begin
               state_d = StStrobe;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StStrobe: begin
            wc_d  = wc_q + 1'b1;
            cnt_d = '0;
`ifdef BITSTREAM_PACKER_CHECKSUM_EN
            cs_d  = cs_q ^ data_q;
`endif
            if (HOLD_CYCLES == 0) begin
               hold_exit = 1'b1;
            end else begin
               state_d = StHold;
            end
         end
         StHold: begin
            if (cnt_q == 16'(HOLD_CYCLES - 1)) begin
               hold_exit = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StDone: begin
            done_d = 1'b1;
         end
         default: state_d = StCollect;
      endcase

      if (hold_exit) begin
         if (wc_d == WordCountW'(MAX_WORDS)) begin
            state_d = StDone;
            done_d  = 1'b1;
         end else begin
            state_d = StCollect;
         end
      end

      if (clear) begin
         state_d = StCollect;
         cnt_d   = '0;
         wc_d    = '0;
         done_d  = 1'b0;
`ifdef BITSTREAM_PACKER_CHECKSUM_EN
         cs_d    = '0;
`endif
      end

      strobe_d = (state_d == StStrobe);
   end

   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         state_q  <= StCollect;
         cnt_q    <= '0;
         data_q   <= '0;
         wc_q     <= '0;
         strobe_q <= 1'b0;
         done_q   <= 1'b0;
`ifdef BITSTREAM_PACKER_CHECKSUM_EN
         cs_q     <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         wc_q     <= wc_d;
         strobe_q <= strobe_d;
         done_q   <= done_d;
`ifdef BITSTREAM_PACKER_CHECKSUM_EN
         cs_q     <= cs_d;
`endif
      end
   end

   assign in_ready        = (state_q == StCollect);
   assign ComActive       = (state_q != StCollect) || (byte_idx != 2'd0);
   assign SelfWriteData   = data_q;
   assign SelfWriteStrobe = strobe_q;
   assign done            = done_q;
   assign word_count      = wc_q;
`ifdef BITSTREAM_PACKER_CHECKSUM_EN
   assign checksum        = cs_q;
`endif

endmodule

// File: tb/tb_bitstream_word_packer.sv
// Bench for bitstream_word_packer: cycle-level reference model, vector table, corner sequences.
module tb_bitstream_word_packer;

   localparam int unsigned S  = 2;
   localparam int unsigned H  = 2;
   localparam int unsigned MW = 4;

   logic        CLK = 1'b0;
   logic        resetn;
   logic        clear;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] SelfWriteData;
   logic        SelfWriteStrobe;
   logic        ComActive;
   logic        done;
   logic [12:0] word_count;
`ifdef BITSTREAM_PACKER_CHECKSUM_EN
   logic [31:0] checksum;
`endif

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   bitstream_word_packer #(
      .SETUP_CYCLES (S),
      .HOLD_CYCLES  (H),
      .MAX_WORDS    (MW)
   ) dut (
      .CLK             (CLK),
      .resetn          (resetn),
      .clear           (clear),
      .in_data         (in_data),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .SelfWriteData   (SelfWriteData),
      .SelfWriteStrobe (SelfWriteStrobe),
      .ComActive       (ComActive),
      .done            (done),
      .word_count      (word_count)
`ifdef BITSTREAM_PACKER_CHECKSUM_EN
      ,
      .checksum        (checksum)
`endif
   );

   // Reference model: cyc is the index of the current cycle (edges taken so far).
   int unsigned cyc;
   logic [7:0]  m_bytes[$];
   bit          m_pending;
   bit          m_done;
   bit          m_acc;
   int unsigned m_n;
   int unsigned m_count;
   logic [31:0] m_data;
   logic [31:0] m_cs;
   int unsigned strobe_cycles[$];
   logic        s_strobe, s_ready, s_done;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic bit exp_ready();
      return !m_done && !m_pending;
   endfunction

   task automatic model_clear();
      m_bytes.delete();
      m_pending = 0;
      m_done    = 0;
      m_count   = 0;
      m_cs      = '0;
   endtask

   task automatic model_reset();
      model_clear();
      m_data = '0;
   endtask

   task automatic model_edge(input logic v, input logic [7:0] d, input logic c);
      bit rdy;
      rdy   = exp_ready();
      m_acc = 0;
      cyc++;
      if (c) begin
         model_clear();
      end else begin
         if (m_pending && cyc == m_n + S + 1) begin
            m_count++;
            m_cs ^= m_data;
         end
         if (m_pending && cyc == m_n + S + H + 1) begin
            m_pending = 0;
            if (m_count == MW) m_done = 1;
         end
         if (v && rdy) begin
            m_acc = 1;
            m_bytes.push_back(d);
            if (m_bytes.size() == 4) begin
               m_data    = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
               m_bytes.delete();
               m_pending = 1;
               m_n       = cyc;
            end
         end
      end
   endtask

   task automatic check_outputs();
      chk("in_ready", 32'(in_ready), 32'(exp_ready()));
      chk("strobe", 32'(SelfWriteStrobe), 32'(m_pending && cyc == m_n + S));
      chk("word_count", 32'(word_count), m_count);
      chk("done", 32'(done), 32'(m_done));
      chk("ComActive", 32'(ComActive), 32'(m_pending || m_done || m_bytes.size() != 0));
      chk("data", SelfWriteData, m_data);
`ifdef BITSTREAM_PACKER_CHECKSUM_EN
      chk("checksum", checksum, m_cs);
`endif
      s_strobe = SelfWriteStrobe;
      s_ready  = in_ready;
      s_done   = done;
      if (SelfWriteStrobe === 1'b1) strobe_cycles.push_back(cyc);
   endtask

   // Called just after a rising edge: drive, sample at the falling edge, then advance.
   task automatic cycle(input logic v, input logic [7:0] d, input logic c);
      in_valid = v;
      in_data  = d;
      clear    = c;
      @(negedge CLK);
      check_outputs();
      @(posedge CLK);
      model_edge(v, d, c);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom), 1'b0);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      do begin
         cycle(1'b1, b, 1'b0);
         n++;
      end while (!m_acc && n < 60);
      if (!m_acc) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout byte %h: got no acceptance required one within 60 cycles", b);
      end
   endtask

   // Latency to the strobe counted in edges from the accepting edge.
   task automatic strobe_latency(output int edges);
      edges = -1;
      for (int k = 0; k < 20 && edges < 0; k++) begin
         cycle(1'b0, 8'h00, 1'b0);
         if (s_strobe === 1'b1) edges = k + 1;
      end
   endtask

   typedef struct {
      logic [7:0]  b0, b1, b2, b3;
      logic [31:0] exp;
      int unsigned wc;
      bit          clr;
   } vec_t;

   vec_t vecs[5];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int edges;
      int n0;

      vecs[0] = '{b0: 8'hDE, b1: 8'hAD, b2: 8'hBE, b3: 8'hEF, exp: 32'hDEADBEEF, wc: 1, clr: 1};
      vecs[1] = '{b0: 8'h01, b1: 8'h02, b2: 8'h03, b3: 8'h04, exp: 32'h01020304, wc: 2, clr: 0};
      vecs[2] = '{b0: 8'h00, b1: 8'h00, b2: 8'hFF, b3: 8'hFF, exp: 32'h0000FFFF, wc: 1, clr: 1};
      vecs[3] = '{b0: 8'hFF, b1: 8'hFF, b2: 8'h00, b3: 8'h00, exp: 32'hFFFF0000, wc: 2, clr: 0};
      vecs[4] = '{b0: 8'h80, b1: 8'h00, b2: 8'h00, b3: 8'h01, exp: 32'h80000001, wc: 3, clr: 0};

      resetn   = 1'b0;
      clear    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      cyc      = 0;
      model_reset();
      @(posedge CLK);
      #1;
      chk("reset_data", SelfWriteData, 32'h0);
      chk("reset_strobe", 32'(SelfWriteStrobe), 32'h0);
      chk("reset_wc", 32'(word_count), 32'h0);
      chk("reset_done", 32'(done), 32'h0);
      chk("reset_active", 32'(ComActive), 32'h0);
      @(posedge CLK);
      #1;
      resetn = 1'b1;

      // Vector table: full-rate words, strobe latency, data and count afterwards.
      foreach (vecs[i]) begin
         if (vecs[i].clr) cycle(1'b0, 8'h00, 1'b1);
         send_byte(vecs[i].b0);
         send_byte(vecs[i].b1);
         send_byte(vecs[i].b2);
         send_byte(vecs[i].b3);
         strobe_latency(edges);
         chk("strobe_edges", 32'(edges), 32'(S + 1));
         idle(H + 1);
         chk("vec_data", SelfWriteData, vecs[i].exp);
         chk("vec_wc", 32'(word_count), vecs[i].wc);
`ifdef BITSTREAM_PACKER_CHECKSUM_EN
         if (i == 3) chk("checksum_ffff", checksum, 32'hFFFFFFFF);
`endif
      end

      // Eight bytes at full rate: two strobes nine cycles apart.
      cycle(1'b0, 8'h00, 1'b1);
      strobe_cycles.delete();
      for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + i));
      idle(12);
      chk("full_rate_strobes", 32'(strobe_cycles.size()), 32'd2);
      if (strobe_cycles.size() == 2)
         chk("strobe_spacing", strobe_cycles[1] - strobe_cycles[0], 32'd9);
      chk("full_rate_wc", 32'(word_count), 32'd2);

      // Same eight bytes with five idle cycles between each byte.
      cycle(1'b0, 8'h00, 1'b1);
      strobe_cycles.delete();
      for (int i = 0; i < 8; i++) begin
         send_byte(8'(8'h10 + i));
         idle(5);
      end
      idle(8);
      chk("gap_strobes", 32'(strobe_cycles.size()), 32'd2);
      chk("gap_wc", 32'(word_count), 32'd2);
      chk("gap_data", SelfWriteData, 32'h14151617);

      // Fill to MAX_WORDS; a seventeenth byte must be refused.
      cycle(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 16; i++) send_byte(8'(8'hA0 + i));
      idle(S + 1 + H);
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 8'h77, 1'b0);
         chk("done_set", 32'(s_done), 32'h1);
         chk("done_not_ready", 32'(s_ready), 32'h0);
      end
      chk("done_wc", 32'(word_count), 32'd4);

      // Clear discards a partial word.
      cycle(1'b0, 8'h00, 1'b1);
      send_byte(8'hAA);
      send_byte(8'hBB);
      cycle(1'b0, 8'h00, 1'b1);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      send_byte(8'h04);
      idle(S + H + 2);
      chk("clear_data", SelfWriteData, 32'h01020304);
      chk("clear_wc", 32'(word_count), 32'd1);

      // Clear coinciding with the strobe cycle: strobe still seen, count returns to 0.
      for (int i = 0; i < 4; i++) send_byte(8'(8'hC0 + i));
      idle(S);
      cycle(1'b0, 8'h00, 1'b1);
      chk("clear_at_strobe_seen", 32'(s_strobe), 32'h1);
      idle(1);
      chk("clear_at_strobe_wc", 32'(word_count), 32'd0);

      // Asynchronous reset during SETUP abandons the word.
      for (int i = 0; i < 4; i++) send_byte(8'(8'h50 + i));
      idle(1);
      resetn = 1'b0;
      #1;
      chk("rst_setup_data", SelfWriteData, 32'h0);
      chk("rst_setup_strobe", 32'(SelfWriteStrobe), 32'h0);
      chk("rst_setup_wc", 32'(word_count), 32'h0);
      chk("rst_setup_active", 32'(ComActive), 32'h0);
      model_reset();
      @(posedge CLK);
      #1;
      resetn = 1'b1;
      n0 = strobe_cycles.size();
      idle(1);
      chk("rst_release_ready", 32'(s_ready), 32'h1);
      idle(10);
      chk("rst_no_strobe", 32'(strobe_cycles.size()), 32'(n0));

      // Random traffic with occasional clears against the model.
      for (int i = 0; i < 2000; i++) begin
         cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 79) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
